// File: rtl/lcd_read_ctrl.sv
// HD44780-style LCD read sequencer: SETUP / E pulse / HOLD timing, with optional
// busy-flag polling until the flag clears or a poll limit is reached.
module lcd_read_ctrl #(
  parameter int T_AS     = 2,
  parameter int T_EH     = 12,
  parameter int T_H      = 2,
  parameter int POLL_MAX = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rs_sel,
  input  logic       poll,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] rd_data,
  output logic       bf,
  output logic [6:0] addr
);

  localparam int TMAX = (T_EH > T_AS) ? ((T_EH > T_H) ? T_EH : T_H)
                                      : ((T_AS > T_H) ? T_AS : T_H);
  localparam int CW = $clog2(TMAX + 1);
  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, E_HIGH, HOLD, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            rs_q, rs_d, poll_q, poll_d, to_d;
  logic [7:0]      sample_q, rd_data_q;
  logic            bf_q;
  logic [6:0]      addr_q;
  logic            e_q, e_d, rs_o_q, rs_o_d, rw_q, rw_d;
  logic            busy_q, busy_d, done_q, done_d, to_q;

  // Outputs are computed from next state and registered, so every pin is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      sample_q  <= 8'h00;
      rd_data_q <= 8'h00;
      bf_q      <= 1'b0;
      addr_q    <= 7'h00;
      e_q       <= 1'b0;
      rs_o_q    <= 1'b0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      rs_q    <= rs_d;
      poll_q  <= poll_d;
      e_q     <= e_d;
      rs_o_q  <= rs_o_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
      if (state_q == E_HIGH && cnt_q == CW'(T_EH - 1))
        sample_q <= lcd_data_in;
      if (state_q == HOLD && state_d == DONE) begin
        rd_data_q <= sample_q;
        if (!rs_q) begin
          bf_q   <= sample_q[7];
          addr_q <= sample_q[6:0];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    rs_d    = rs_q;
    poll_d  = poll_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: if (req) begin
        state_d = SETUP;
        cnt_d   = '0;
        pcnt_d  = '0;
        rs_d    = rs_sel;
        poll_d  = poll;
      end
      SETUP: if (cnt_q == CW'(T_AS - 1)) begin
        state_d = E_HIGH;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CW'(1);
      E_HIGH: if (cnt_q == CW'(T_EH - 1)) begin
        state_d = HOLD;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CW'(1);
      HOLD: if (cnt_q == CW'(T_H - 1)) begin
        cnt_d = '0;
        // Busy flag still set on a polled status read: retry until the limit.
        if (poll_q && !rs_q && sample_q[7]) begin
          if (pcnt_q < PW'(POLL_MAX - 1)) begin
            state_d = SETUP;
            pcnt_d  = pcnt_q + PW'(1);
          end else begin
            state_d = DONE;
            to_d    = 1'b1;
          end
        end else state_d = DONE;
      end else cnt_d = cnt_q + CW'(1);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    e_d    = 1'b0;
    rw_d   = 1'b0;
    rs_o_d = 1'b0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    case (state_d)
      SETUP, E_HIGH, HOLD: begin
        rw_d   = 1'b1;
        rs_o_d = rs_d;
        e_d    = (state_d == E_HIGH);
      end
      DONE:    rs_o_d = rs_d;
      default: ;
    endcase
  end

  assign lcd_e   = e_q;
  assign lcd_rs  = rs_o_q;
  assign lcd_rw  = rw_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = to_q;
  assign rd_data = rd_data_q;
  assign bf      = bf_q;
  assign addr    = addr_q;

endmodule
